// File: rtl/ahb_sram_pkg.sv
// Shared AHB encodings, default widths and the transfer byte-lane helper
// used by the AHB-Lite SRAM controller.
package ahb_sram_pkg;

   localparam int AW_DEF       = 15;
   localparam int WORDS_AW_DEF = 13;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   // Active-high byte lanes touched by a transfer; anything wider than a word
   // is clamped to the full word.
   function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr_lo);
      if (size == HSIZE_BYTE)
         return 4'b0001 << addr_lo;
      else if (size == HSIZE_HALF)
         return addr_lo[1] ? 4'b1100 : 4'b0011;
      else
         return 4'b1111;
   endfunction

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite bus bundle between the interconnect (master) and the SRAM
// controller (slave).
interface ahb_sram_ctrl_if
   import ahb_sram_pkg::*;
#(
   parameter int AW = AW_DEF
);
   logic          HSEL;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted write buffer with read-after-write byte merge: holds the
// last write until the SRAM port is free and patches it into read data.
module ahb_sram_wbuf
   import ahb_sram_pkg::*;
#(
   parameter int WORDS_AW = WORDS_AW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [WORDS_AW-1:0] load_addr,
   input  logic [3:0]          load_mask,
   input  logic [31:0]         load_data,
   input  logic                drain,
   input  logic                rd_ap,
   input  logic [WORDS_AW-1:0] rd_addr,
   input  logic [31:0]         sram_q,
   output logic                buf_full,
   output logic [WORDS_AW-1:0] buf_addr,
   output logic [3:0]          buf_mask,
   output logic [31:0]         buf_data,
   output logic [31:0]         rdata
);

   logic                buf_full_nxt;
   logic [WORDS_AW-1:0] buf_addr_nxt;
   logic                rd_merge;

   // The hit compare looks at next-state so a write landing in the same cycle
   // as the read address phase is still merged.
   assign buf_full_nxt = load | (buf_full & ~drain);
   assign buf_addr_nxt = load ? load_addr : buf_addr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_full <= 1'b0;
         buf_addr <= '0;
         buf_mask <= '0;
         buf_data <= '0;
         rd_merge <= 1'b0;
      end else begin
         buf_full <= buf_full_nxt;
         rd_merge <= rd_ap & buf_full_nxt & (buf_addr_nxt == rd_addr);
         if (load) begin
            buf_addr <= load_addr;
            buf_mask <= load_mask;
            buf_data <= load_data;
         end
      end
   end

   // NOTE: rdata takes its default before the loop so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      rdata = sram_q;
      for (int i = 0; i < 4; i++) begin
         if (rd_merge && buf_mask[i])
            rdata[8*i +: 8] = buf_data[8*i +: 8];
      end
   end

   // A load into a still-full, non-draining buffer would silently lose a write.
   a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
      !(load && buf_full && !drain));

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite subordinate for a single-port 8192x32 byte-enabled SRAM: zero-wait
// reads, posted writes through a one-entry buffer, reads always win the port.
module ahb_sram_ctrl
   import ahb_sram_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int WORDS_AW = WORDS_AW_DEF
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   ahb_sram_ctrl_if.slave      ahb,
   input  logic [31:0]         SRAM_Q,
   output logic                SRAM_CEN,
   output logic                SRAM_GWEN,
   output logic [3:0]          SRAM_BEN,
   output logic [WORDS_AW-1:0] SRAM_A,
   output logic [31:0]         SRAM_D
);

   logic                acc, rd_ap, wr_ap;
   logic [WORDS_AW-1:0] ap_word;
   logic                wr_dp, rd_dp;
   logic [WORDS_AW-1:0] wr_addr;
   logic [3:0]          wr_mask;
   logic [WORDS_AW-1:0] a_hold;
   logic [31:0]         d_hold;
   logic                buf_full, drain;
   logic [WORDS_AW-1:0] buf_addr;
   logic [3:0]          buf_mask;
   logic [31:0]         buf_data;
   logic [31:0]         merged_q;

   assign acc     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
   assign rd_ap   = acc & ~ahb.HWRITE;
   assign wr_ap   = acc & ahb.HWRITE;
   assign ap_word = ahb.HADDR[AW-1:2];
   assign drain   = buf_full & ~rd_ap;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_dp   <= 1'b0;
         rd_dp   <= 1'b0;
         wr_addr <= '0;
         wr_mask <= '0;
         a_hold  <= '0;
         d_hold  <= '0;
      end else begin
         wr_dp  <= wr_ap;
         rd_dp  <= rd_ap;
         a_hold <= SRAM_A;
         d_hold <= SRAM_D;
         if (wr_ap) begin
            wr_addr <= ap_word;
            wr_mask <= byte_mask(ahb.HSIZE, ahb.HADDR[1:0]);
         end
      end
   end

   // Idle cycles replay the last address/data so the SRAM pins do not toggle.
   always_comb begin
      SRAM_CEN  = 1'b1;
      SRAM_GWEN = 1'b1;
      SRAM_BEN  = 4'hF;
      SRAM_A    = a_hold;
      SRAM_D    = d_hold;
      if (rd_ap) begin
         SRAM_CEN = 1'b0;
         SRAM_A   = ap_word;
      end else if (buf_full) begin
         SRAM_CEN  = 1'b0;
         SRAM_GWEN = 1'b0;
         SRAM_BEN  = ~buf_mask;
         SRAM_A    = buf_addr;
         SRAM_D    = buf_data;
      end
   end

   ahb_sram_wbuf #(.WORDS_AW(WORDS_AW)) u_wbuf (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .load      (wr_dp),
      .load_addr (wr_addr),
      .load_mask (wr_mask),
      .load_data (ahb.HWDATA),
      .drain     (drain),
      .rd_ap     (rd_ap),
      .rd_addr   (ap_word),
      .sram_q    (SRAM_Q),
      .buf_full  (buf_full),
      .buf_addr  (buf_addr),
      .buf_mask  (buf_mask),
      .buf_data  (buf_data),
      .rdata     (merged_q)
   );

   assign ahb.HREADYOUT = 1'b1;
   assign ahb.HRESP     = 1'b0;
   assign ahb.HRDATA    = rd_dp ? merged_q : 32'h0;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: behavioural SRAM, architectural reference memory and
// a read-data scoreboard fed at each read address phase.
module tb_ahb_sram_ctrl;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b0;
   logic [31:0] sram_q;
   logic        sram_cen, sram_gwen;
   logic [3:0]  sram_ben;
   logic [12:0] sram_a;
   logic [31:0] sram_d;

   logic [31:0] sram_mem [0:8191];
   logic [31:0] ref_mem  [0:8191];
   int          sram_writes = 0;
   logic        poke_en = 1'b0;
   logic [12:0] poke_addr = '0;
   logic [31:0] poke_data = '0;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic        pend_rd = 1'b0, pend_wr = 1'b0;
   logic [12:0] pend_word = '0;
   logic [3:0]  pend_mask = '0;
   logic [31:0] pend_data = '0;
   logic        hready_drv = 1'b1;

   ahb_sram_ctrl_if #(.AW(15)) bus ();

   ahb_sram_ctrl #(.AW(15), .WORDS_AW(13)) dut (
      .HCLK      (hclk),
      .HRESETn   (hresetn),
      .ahb       (bus),
      .SRAM_Q    (sram_q),
      .SRAM_CEN  (sram_cen),
      .SRAM_GWEN (sram_gwen),
      .SRAM_BEN  (sram_ben),
      .SRAM_A    (sram_a),
      .SRAM_D    (sram_d)
   );

   always #5 hclk = ~hclk;

   // Behavioural SRAM: synchronous read, byte-enabled write, backdoor poke.
   always @(posedge hclk) begin
      if (poke_en)
         sram_mem[poke_addr] <= poke_data;
      else if (!sram_cen) begin
         if (!sram_gwen) begin
            for (int i = 0; i < 4; i++)
               if (!sram_ben[i]) sram_mem[sram_a][8*i +: 8] <= sram_d[8*i +: 8];
            sram_writes <= sram_writes + 1;
         end else
            sram_q <= sram_mem[sram_a];
      end
   end

   function automatic logic [3:0] tb_mask(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         3'd0: case (lo)
                  2'd0: return 4'b0001;
                  2'd1: return 4'b0010;
                  2'd2: return 4'b0100;
                  default: return 4'b1000;
               endcase
         3'd1: return (lo >= 2'd2) ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   // Drives one address phase (plus the data phase of the previous write),
   // then checks HRDATA mid-cycle against the scoreboard. Ends mid-cycle.
   task automatic drive(input logic sel, input logic [1:0] trans, input logic write,
                        input logic [2:0] size, input logic [14:0] addr, input logic [31:0] wdata);
      logic a;
      logic [31:0] e;
      if (pend_wr) begin
         bus.HWDATA = pend_data;
         for (int i = 0; i < 4; i++)
            if (pend_mask[i]) ref_mem[pend_word][8*i +: 8] = pend_data[8*i +: 8];
      end else
         bus.HWDATA = $urandom();
      bus.HSEL   = sel;
      bus.HTRANS = trans;
      bus.HWRITE = write;
      bus.HSIZE  = size;
      bus.HADDR  = addr;
      bus.HREADY = hready_drv;
      a = sel & hready_drv & trans[1];
      if (a && !write) exp_q.push_back(ref_mem[addr[14:2]]);
      #4;
      total++;
      if (pend_rd) begin
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL hrdata: got=%h with no expected entry", bus.HRDATA);
         end else begin
            e = exp_q.pop_front();
            if (bus.HRDATA !== e) begin
               bad++;
               $display("FAIL hrdata: got=%h exp=%h", bus.HRDATA, e);
            end
         end
      end else if (bus.HRDATA !== 32'h0) begin
         bad++;
         $display("FAIL hrdata_idle: got=%h exp=00000000", bus.HRDATA);
      end
      pend_rd   = a & ~write;
      pend_wr   = a & write;
      pend_word = addr[14:2];
      pend_mask = tb_mask(size, addr[1:0]);
      pend_data = wdata;
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 1'b0, 3'd2, 15'h0, 32'h0);
      tick();
   endtask

   task automatic op_rd(input logic [14:0] addr);
      drive(1'b1, 2'b10, 1'b0, 3'd2, addr, 32'h0);
      tick();
   endtask

   task automatic op_wr(input logic [2:0] size, input logic [14:0] addr, input logic [31:0] d);
      drive(1'b1, 2'b10, 1'b1, size, addr, d);
      tick();
   endtask

   task automatic poke(input logic [12:0] w, input logic [31:0] d);
      poke_en = 1'b1; poke_addr = w; poke_data = d;
      ref_mem[w] = d;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic test_reset();
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'd2;
      bus.HADDR = '0; bus.HWDATA = '0; bus.HREADY = 1'b1;
      #3;
      total++;
      if ({sram_cen, sram_gwen, sram_ben} !== 6'b11_1111) begin
         bad++;
         $display("FAIL reset_sram: got=%b exp=111111", {sram_cen, sram_gwen, sram_ben});
      end
      total++;
      if ({bus.HRDATA, bus.HREADYOUT, bus.HRESP} !== {32'h0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_ahb: got=%h/%b/%b exp=00000000/1/0", bus.HRDATA, bus.HREADYOUT, bus.HRESP);
      end
      @(posedge hclk); @(posedge hclk); #1;
      hresetn = 1'b1;
      tick();
   endtask

   task automatic test_word_write();
      op_wr(3'd2, 15'h0010, 32'hDEAD_BEEF);
      drive(1'b0, 2'b00, 1'b0, 3'd2, 15'h0, 32'h0);
      total++;
      if (sram_cen !== 1'b1) begin
         bad++;
         $display("FAIL ww_dp_cen: got=%b exp=1", sram_cen);
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, 3'd2, 15'h0, 32'h0);
      total++;
      if ({sram_cen, sram_gwen, sram_ben, sram_a, sram_d} !== {1'b0, 1'b0, 4'h0, 13'h004, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL ww_drain: got cen=%b gwen=%b ben=%h a=%h d=%h exp 0/0/0/004/deadbeef",
                  sram_cen, sram_gwen, sram_ben, sram_a, sram_d);
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, 3'd2, 15'h0, 32'h0);
      total++;
      if ({sram_cen, sram_gwen, sram_a} !== {1'b1, 1'b1, 13'h004}) begin
         bad++;
         $display("FAIL ww_after: got cen=%b gwen=%b a=%h exp 1/1/004", sram_cen, sram_gwen, sram_a);
      end
      tick();
      total++;
      if (sram_mem[4] !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL ww_mem: got=%h exp=deadbeef", sram_mem[4]);
      end
   endtask

   task automatic test_back_to_back();
      poke(13'h0, 32'h1111_1111);
      poke(13'h1, 32'h2222_2222);
      drive(1'b1, 2'b10, 1'b0, 3'd2, 15'h0000, 32'h0);
      total++;
      if ({sram_cen, sram_gwen, bus.HREADYOUT} !== 3'b011) begin
         bad++;
         $display("FAIL b2b_ap0: got=%b exp=011", {sram_cen, sram_gwen, bus.HREADYOUT});
      end
      tick();
      drive(1'b1, 2'b10, 1'b0, 3'd2, 15'h0004, 32'h0);
      total++;
      if ({sram_cen, sram_gwen, bus.HREADYOUT} !== 3'b011) begin
         bad++;
         $display("FAIL b2b_ap1: got=%b exp=011", {sram_cen, sram_gwen, bus.HREADYOUT});
      end
      tick();
      idle();
   endtask

   task automatic test_raw_merge();
      poke(13'h40, 32'h5555_5555);
      op_wr(3'd0, 15'h0102, 32'h00AB_0000);
      op_rd(15'h0100);
      drive(1'b0, 2'b00, 1'b0, 3'd2, 15'h0, 32'h0);
      total++;
      if ({sram_cen, sram_gwen, sram_ben, sram_a} !== {1'b0, 1'b0, 4'b1011, 13'h040}) begin
         bad++;
         $display("FAIL merge_drain: got cen=%b gwen=%b ben=%b a=%h exp 0/0/1011/040",
                  sram_cen, sram_gwen, sram_ben, sram_a);
      end
      tick();
      idle();
      total++;
      if (sram_mem[13'h40] !== 32'h55AB_5555) begin
         bad++;
         $display("FAIL merge_mem: got=%h exp=55ab5555", sram_mem[13'h40]);
      end
   endtask

   task automatic test_alternating();
      logic        wr_t [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [14:0] ad_t [6] = '{15'h20, 15'h40, 15'h24, 15'h20, 15'h40, 15'h24};
      poke(13'h10, 32'hA5A5_0010);
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 6; k++) begin
            if (wr_t[k]) op_wr(3'd2, ad_t[k], $urandom());
            else         op_rd(ad_t[k]);
         end
      end
      op_wr(3'd2, 15'h24, $urandom());
      op_rd(15'h24);
      idle(); idle(); idle();
      for (int w = 8; w <= 16; w += 8) begin
         total++;
         if (sram_mem[w] !== ref_mem[w]) begin
            bad++;
            $display("FAIL alt_mem[%0d]: got=%h exp=%h", w, sram_mem[w], ref_mem[w]);
         end
      end
      total++;
      if (sram_mem[9] !== ref_mem[9]) begin
         bad++;
         $display("FAIL alt_mem[9]: got=%h exp=%h", sram_mem[9], ref_mem[9]);
      end
   endtask

   task automatic test_halfword();
      op_wr(3'd1, 15'h0006, 32'h1234_0000);
      idle();
      drive(1'b0, 2'b00, 1'b0, 3'd2, 15'h0, 32'h0);
      total++;
      if ({sram_cen, sram_gwen, sram_ben} !== {1'b0, 1'b0, 4'b0011}) begin
         bad++;
         $display("FAIL half_ben: got cen=%b gwen=%b ben=%b exp 0/0/0011", sram_cen, sram_gwen, sram_ben);
      end
      tick();
      total++;
      if (ref_mem[1] !== 32'h1234_2222) begin
         bad++;
         $display("FAIL half_ref: got=%h exp=12342222", ref_mem[1]);
      end
      op_rd(15'h0004);
      idle();
   endtask

   task automatic test_no_select();
      hready_drv = 1'b0;
      drive(1'b1, 2'b10, 1'b0, 3'd2, 15'h0000, 32'h0);
      total++;
      if (sram_cen !== 1'b1) begin
         bad++;
         $display("FAIL hready_low_cen: got=%b exp=1", sram_cen);
      end
      tick();
      hready_drv = 1'b1;
      drive(1'b0, 2'b10, 1'b0, 3'd2, 15'h0000, 32'h0);
      total++;
      if (sram_cen !== 1'b1) begin
         bad++;
         $display("FAIL hsel_low_cen: got=%b exp=1", sram_cen);
      end
      tick();
      drive(1'b1, 2'b01, 1'b0, 3'd2, 15'h0000, 32'h0);
      total++;
      if (sram_cen !== 1'b1) begin
         bad++;
         $display("FAIL busy_cen: got=%b exp=1", sram_cen);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_pending();
      logic [31:0] old;
      int          wr_before;
      poke(13'h0C, 32'hCAFE_0001);
      old = 32'hCAFE_0001;
      op_wr(3'd2, 15'h0030, 32'h0BAD_F00D);
      idle();
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
      #1;
      total++;
      if ({sram_cen, sram_gwen} !== 2'b00) begin
         bad++;
         $display("FAIL rst_pending: got=%b exp=00", {sram_cen, sram_gwen});
      end
      wr_before = sram_writes;
      hresetn = 1'b0;
      #1;
      total++;
      if ({sram_cen, sram_gwen, sram_ben, bus.HRDATA} !== {1'b1, 1'b1, 4'hF, 32'h0}) begin
         bad++;
         $display("FAIL rst_async: got cen=%b gwen=%b ben=%h hrdata=%h exp 1/1/f/00000000",
                  sram_cen, sram_gwen, sram_ben, bus.HRDATA);
      end
      @(posedge hclk); @(posedge hclk); #1;
      hresetn = 1'b1;
      ref_mem[13'h0C] = old;
      pend_rd = 1'b0; pend_wr = 1'b0;
      exp_q.delete();
      idle(); idle();
      total++;
      if (sram_writes !== wr_before) begin
         bad++;
         $display("FAIL rst_no_write: got=%0d exp=%0d", sram_writes, wr_before);
      end
      op_rd(15'h0030);
      idle();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left: got=%0d exp=0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_word_write();
      test_back_to_back();
      test_raw_merge();
      test_alternating();
      test_halfword();
      test_no_select();
      test_reset_pending();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
